// File: rtl/display_view_scheduler.sv
// display_view_scheduler: parking timer (mm:ss) plus capacity/time view
// sequencing for the multiplexed display. All outputs registered.
// Optional macro FULL_FLASH_EN: blink the display (blank) while the
// capacity view shows a full lot (capacity==0).
module display_view_scheduler #(
   parameter int TICKS_PER_SEC = 500,
   parameter int CAP_DWELL     = 3,
   parameter int TIME_DWELL    = 5
) (
   input  logic       clk_500Hz,
   input  logic       reset,
   input  logic       start,
   input  logic       stop,
   input  logic       view_btn,
   input  logic [2:0] capacity,
   output logic       mode,
   output logic [5:0] minutes,
   output logic [5:0] seconds,
   output logic       running,
   output logic       sec_tick,
   output logic       blank
);

   localparam int PW   = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
   localparam int DMAX = (CAP_DWELL > TIME_DWELL) ? CAP_DWELL : TIME_DWELL;
   localparam int DW   = (DMAX > 1) ? $clog2(DMAX + 1) : 1;

   localparam logic [PW-1:0] PRESC_LAST = PW'(TICKS_PER_SEC - 1);
   localparam logic [DW-1:0] CAP_LAST   = DW'(CAP_DWELL - 1);
   localparam logic [DW-1:0] TIME_LAST  = DW'(TIME_DWELL - 1);

   typedef enum logic {CAP_VIEW = 1'b0, TIME_VIEW = 1'b1} state_t;

   state_t        state_q, state_d;
   logic [PW-1:0] presc_q, presc_d;
   logic [DW-1:0] dwell_q, dwell_d;
   logic [5:0]    min_q, min_d, sec_q, sec_d;
   logic          run_q, run_d;
   logic          tick_q, tick_d;
   logic          mode_q, mode_d;
   logic          blank_q, blank_d;
   logic          wrap;

   // A timer second ends on the cycle the prescaler wraps; start restarts the second.
   assign wrap = (presc_q == PRESC_LAST) && !start;

   // Prescaler and one-cycle second pulse.
   always_comb begin
      presc_d = presc_q + 1'b1;
      tick_d  = 1'b0;
      if (start) begin
         presc_d = '0;
      end else if (presc_q == PRESC_LAST) begin
         presc_d = '0;
         tick_d  = 1'b1;
      end
   end

   // Parking timer: restart on start, freeze on stop, saturate at 59:59.
   always_comb begin
      min_d = min_q;
      sec_d = sec_q;
      run_d = run_q;
      if (start) begin
         min_d = '0;
         sec_d = '0;
         run_d = 1'b1;
      end else if (stop) begin
         run_d = 1'b0;
      end else if (wrap && run_q) begin
         if (sec_q != 6'd59) begin
            sec_d = sec_q + 1'b1;
         end else if (min_q != 6'd59) begin
            sec_d = '0;
            min_d = min_q + 1'b1;
         end
      end
   end

   // View FSM: gate events, then the button, then dwell rotation; any entry clears dwell.
   always_comb begin
      state_d = state_q;
      dwell_d = dwell_q;
      if (start || stop) begin
         state_d = TIME_VIEW;
         dwell_d = '0;
      end else if (view_btn) begin
         state_d = (state_q == CAP_VIEW) ? TIME_VIEW : CAP_VIEW;
         dwell_d = '0;
      end else if (wrap) begin
         if (state_q == TIME_VIEW) begin
            if (dwell_q == TIME_LAST) begin
               state_d = CAP_VIEW;
               dwell_d = '0;
            end else begin
               dwell_d = dwell_q + 1'b1;
            end
         end else if (run_q) begin
            // Idle capacity view never rotates, so its dwell simply holds.
            if (dwell_q == CAP_LAST) begin
               state_d = TIME_VIEW;
               dwell_d = '0;
            end else begin
               dwell_d = dwell_q + 1'b1;
            end
         end
      end
      mode_d = (state_d == TIME_VIEW);
   end

`ifdef FULL_FLASH_EN
   // Full-lot flash: toggle each second while showing capacity with no free slot.
   always_comb begin
      blank_d = 1'b0;
      if (state_d == CAP_VIEW && capacity == 3'd0)
         blank_d = wrap ? !blank_q : blank_q;
   end
`else
   logic unused_capacity;
   assign unused_capacity = ^capacity;

   // No flash support: display never blanked.
   always_comb begin
      blank_d = 1'b0;
   end
`endif

   // State registers with synchronous reset.
   always_ff @(posedge clk_500Hz) begin
      if (reset) begin
         state_q <= CAP_VIEW;
         presc_q <= '0;
         dwell_q <= '0;
         min_q   <= '0;
         sec_q   <= '0;
         run_q   <= 1'b0;
         tick_q  <= 1'b0;
         mode_q  <= 1'b0;
         blank_q <= 1'b0;
      end else begin
         state_q <= state_d;
         presc_q <= presc_d;
         dwell_q <= dwell_d;
         min_q   <= min_d;
         sec_q   <= sec_d;
         run_q   <= run_d;
         tick_q  <= tick_d;
         mode_q  <= mode_d;
         blank_q <= blank_d;
      end
   end

   assign mode     = mode_q;
   assign minutes  = min_q;
   assign seconds  = sec_q;
   assign running  = run_q;
   assign sec_tick = tick_q;
   assign blank    = blank_q;

endmodule

// File: tb/tb_display_view_scheduler.sv
// Bench for display_view_scheduler: directed scenarios plus random pulses,
// checked every cycle against a seconds-based reference model.
module tb_display_view_scheduler;

   localparam int T  = 5;
   localparam int CD = 3;
   localparam int TD = 5;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       start = 1'b0, stop = 1'b0, view_btn = 1'b0;
   logic [2:0] capacity = 3'd4;
   logic       mode, running, sec_tick, blank;
   logic [5:0] minutes, seconds;

   int errors = 0;
   int checks = 0;

   // Reference model state: elapsed seconds as one integer, view and seconds spent in it.
   int  m_phase, m_elapsed, m_siv;
   bit  m_run, m_view, m_tick, m_blank;

   display_view_scheduler #(.TICKS_PER_SEC(T), .CAP_DWELL(CD), .TIME_DWELL(TD)) dut (
      .clk_500Hz(clk), .reset(reset), .start(start), .stop(stop), .view_btn(view_btn),
      .capacity(capacity), .mode(mode), .minutes(minutes), .seconds(seconds),
      .running(running), .sec_tick(sec_tick), .blank(blank)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input int got, input int exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      m_phase = 0; m_elapsed = 0; m_siv = 0;
      m_run = 0; m_view = 0; m_tick = 0; m_blank = 0;
   endtask

   task automatic model_step(input bit st, input bit sp, input bit vb, input int cap);
      bit tk, old_run;
      tk = (m_phase == T - 1) && !st;
      m_phase = st ? 0 : (m_phase + 1) % T;
      m_tick = (m_phase == 0) && !st;
      old_run = m_run;
      if (st) begin
         m_elapsed = 0; m_run = 1;
      end else if (sp) begin
         m_run = 0;
      end else if (tk && m_run) begin
         m_elapsed = (m_elapsed < 3599) ? m_elapsed + 1 : 3599;
      end
      if (st || sp) begin
         m_view = 1; m_siv = 0;
      end else if (vb) begin
         m_view = !m_view; m_siv = 0;
      end else if (tk) begin
         m_siv++;
         if (m_view && m_siv == TD) begin
            m_view = 0; m_siv = 0;
         end else if (!m_view && old_run && m_siv == CD) begin
            m_view = 1; m_siv = 0;
         end
      end
`ifdef FULL_FLASH_EN
      if (!m_view && cap == 0) m_blank = tk ? !m_blank : m_blank;
      else m_blank = 0;
`else
      m_blank = 0;
`endif
   endtask

   task automatic check_all();
      chk("mode", int'(mode), int'(m_view));
      chk("minutes", int'(minutes), m_elapsed / 60);
      chk("seconds", int'(seconds), m_elapsed % 60);
      chk("running", int'(running), int'(m_run));
      chk("sec_tick", int'(sec_tick), int'(m_tick));
      chk("blank", int'(blank), int'(m_blank));
   endtask

   task automatic cyc(input bit st, input bit sp, input bit vb, input int cap);
      @(negedge clk);
      reset = 0; start = st; stop = sp; view_btn = vb; capacity = 3'(cap);
      @(posedge clk);
      model_step(st, sp, vb, cap);
      #1 check_all();
   endtask

   task automatic do_reset(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         reset = 1; start = 0; stop = 0; view_btn = 0;
         @(posedge clk);
         model_reset();
         #1 check_all();
      end
   endtask

   task automatic idle(input int n, input int cap);
      for (int i = 0; i < n; i++) cyc(0, 0, 0, cap);
   endtask

   initial begin
      int ticks;
      model_reset();
      // Reset and free-running second pulse.
      do_reset(3);
      chk("rst_mode", int'(mode), 0);
      chk("rst_running", int'(running), 0);
      ticks = 0;
      for (int i = 0; i < 20; i++) begin
         cyc(0, 0, 0, 4);
         ticks += int'(sec_tick);
      end
      chk("tick_count_20cyc", ticks, 4);

      // Start: time view, counting, rotation 5 s time / 3 s capacity.
      cyc(1, 0, 0, 4);
      chk("start_mode", int'(mode), 1);
      chk("start_running", int'(running), 1);
      idle(5, 4);
      chk("sec_after_5", int'(seconds), 1);
      idle(10, 4);
      chk("sec_after_15", int'(seconds), 3);
      idle(10, 4);
      chk("time_dwell_end", int'(mode), 0);
      idle(15, 4);
      chk("cap_dwell_end", int'(mode), 1);

      // Saturation at 59:59.
      cyc(1, 0, 0, 4);
      idle(3599 * T, 4);
      chk("sat_min", int'(minutes), 59);
      chk("sat_sec", int'(seconds), 59);
      idle(2 * T, 4);
      chk("sat_hold_sec", int'(seconds), 59);
      chk("sat_running", int'(running), 1);

      // Stop at 00:07, then idle capacity view never rotates.
      cyc(1, 0, 0, 4);
      idle(7 * T, 4);
      cyc(0, 1, 0, 4);
      chk("stop_running", int'(running), 0);
      chk("stop_mode", int'(mode), 1);
      chk("stop_sec", int'(seconds), 7);
      idle(5 * T, 4);
      chk("stop_dwell_mode", int'(mode), 0);
      idle(20 * T, 4);
      chk("idle_no_rotate", int'(mode), 0);
      cyc(0, 1, 0, 4);
      chk("stop_idle_mode", int'(mode), 1);
      idle(5 * T, 4);

      // View button while idle, then button coinciding with start.
      cyc(0, 0, 1, 4);
      chk("btn_mode", int'(mode), 1);
      idle(5 * T, 4);
      chk("btn_dwell_mode", int'(mode), 0);
      cyc(1, 0, 1, 4);
      chk("btn_start_mode", int'(mode), 1);
      chk("btn_start_sec", int'(seconds), 0);
      cyc(1, 1, 0, 4);
      chk("start_wins_run", int'(running), 1);

      // Full-lot flash in idle capacity view.
      do_reset(1);
      idle(4 * T, 0);
      idle(2, 2);
      idle(3 * T, 0);

      // Random pulses.
      for (int i = 0; i < 4000; i++) begin
         if ($urandom_range(0, 999) == 0) do_reset(1);
         else cyc($urandom_range(0, 199) == 0, $urandom_range(0, 99) == 0,
                  $urandom_range(0, 59) == 0, (i / 40) % 2 == 0 ? 0 : int'($urandom_range(0, 4)));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/display_view_scheduler.md
Name: display_view_scheduler

Overview:
- Controller for the parking multiplexed display; generates its `mode`, `minutes` and `seconds` inputs.
- Keeps the per-visit parking timer (mm:ss) from a prescaled 1 Hz tick.
- Sequences the display between capacity/slot view (mode=0) and time view (mode=1), driven by car entry/exit events, a user view request and automatic dwell rotation.
- Sits between the gate/sensor logic and the display; runs on the same 500 Hz display clock.

Parameters:
- TICKS_PER_SEC, 500, clk_500Hz cycles per timer second (benches use 5).
- CAP_DWELL, 3, seconds spent in capacity view per rotation while timer running.
- TIME_DWELL, 5, seconds spent in time view per rotation or after a request/exit.

Ports:
- clk_500Hz  input  1  display clock, all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  one-cycle pulse: car entered, restart timer.
- stop  input  1  one-cycle pulse: car exited, freeze timer.
- view_btn  input  1  one-cycle pulse (already debounced): toggle current view.
- capacity  input  3  free slots (0..4), used only by optional feature.
- mode  output  1  0=capacity/slot view, 1=time view, to display.
- minutes  output  6  timer minutes 0..59.
- seconds  output  6  timer seconds 0..59.
- running  output  1  timer counting.
- sec_tick  output  1  one-cycle pulse per timer second.
- blank  output  1  display blank request (optional feature, else 0).

Behaviour:
- All outputs registered. Reset (reset=1 at an edge) forces mode=0, minutes=0, seconds=0, running=0, sec_tick=0, blank=0, prescaler=0, dwell=0, FSM=CAP_VIEW. Reset has priority over every input at that edge, including mid-count and mid-dwell.
- Prescaler: free-running 0..TICKS_PER_SEC-1. At the edge where it wraps to 0, sec_tick=1 for exactly that cycle, otherwise 0. Width is clog2(TICKS_PER_SEC).
- start: prescaler cleared to 0, minutes=seconds=0, running=1. The first sec_tick occurs exactly TICKS_PER_SEC cycles later.
- Timer: on sec_tick with running=1:
  - seconds increments.
  - At 59 it wraps to 0 and minutes increments.
  - At 59:59 the timer saturates: it holds 59:59 and running stays 1.
- stop: running=0 and the value is frozen. A stop with running=0 still forces TIME_VIEW.
- start and stop in the same cycle: start wins and stop is ignored.
- FSM states: CAP_VIEW (mode=0), TIME_VIEW (mode=1). The dwell counter counts sec_ticks since entering the state.
- Every state entry or re-entry clears dwell to 0. mode updates at the same edge as the transition.
- Transition priority per edge (highest first): reset, start, stop, view_btn, dwell expiry.
  - start or stop: go to TIME_VIEW.
  - view_btn: toggle state.
  - Dwell expiry (sec_tick with dwell==DWELL-1):
    - TIME_VIEW goes to CAP_VIEW after TIME_DWELL.
    - CAP_VIEW goes to TIME_VIEW after CAP_DWELL, only if running=1.
    - With running=0, CAP_VIEW never expires.
- view_btn in the same cycle as start or stop is ignored.
- Steady state with running=0 is CAP_VIEW, mode=0.

Optional Feature:
- Macro FULL_FLASH_EN.
- Defined: while state=CAP_VIEW and capacity==0, blank toggles on each sec_tick (1 s on, 1 s off), starting at 1 on the first sec_tick after the condition holds. blank is cleared to 0 at the edge where the state leaves CAP_VIEW or capacity becomes nonzero.
- Undefined: blank is constant 0, capacity is unused, no flash logic is synthesized.

Test Plan:
- TICKS_PER_SEC=5: hold reset 3 cycles, release → mode=0, minutes=0, seconds=0, running=0, blank=0, and sec_tick pulses every 5 cycles.
- Pulse start → mode=1 and running=1 next edge; seconds=1 after 5 cycles, 3 after 15. After TIME_DWELL=5 s, mode=0; after a further 3 s, mode=1 again.
- Preload by running 3599 s (or force) → 59:59, then one more tick → still 59:59 and running=1.
- start running, then stop at 00:07 → running=0, mode=1, values hold 00:07. After 5 s mode=0, and it stays 0 for 20 s with no rotation.
- running=0 in CAP_VIEW, pulse view_btn → mode=1 for 5 s, then mode=0. Pulse view_btn and start together → timer 00:00, mode=1, no toggle.
- FULL_FLASH_EN defined, capacity=0, mode=0 → blank toggles 1,0,1 on successive sec_ticks. Set capacity=2 → blank=0 next edge. Without the macro, blank=0 throughout.
